// File: rtl/bus_arbit_nrr.sv
// ---------------------------------------------------------------------------
// bus_arbit_nrr : N-master bus arbiter, fixed-priority or round-robin, hold limit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_arbit_nrr #(
  parameter int N_MST    = 4,
  parameter int IDX_W    = 2,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_MST-1:0] req,
  output logic [N_MST-1:0] grt,
  output logic [IDX_W-1:0] msel,
  output logic             handover
);

  logic [IDX_W-1:0] r_owner;
  logic [CNT_W-1:0] r_hcnt;
  logic             r_handover;

  logic [N_MST-1:0] w_own_mask;
  logic [N_MST-1:0] w_others;
  logic             w_own_req;
  logic             w_limit;
  logic [IDX_W-1:0] w_win;
  logic             w_found;
  int               w_idx;
  logic [IDX_W-1:0] w_owner_nxt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic             w_switch;

  assign w_own_mask = {{(N_MST-1){1'b0}}, 1'b1} << r_owner;
  assign w_others   = req & ~w_own_mask;
  assign w_own_req  = |(req & w_own_mask);
  // A saturated counter must still trigger, otherwise a late requester starves.
  assign w_limit    = (MAX_HOLD != 0) && (r_hcnt >= CNT_W'(MAX_HOLD - 1));

  // Winner search; in round-robin the scan starts just after the owner.
  always_comb begin
    w_win   = r_owner;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N_MST; i++) begin
      if (MODE == 0) w_idx = i;
      else           w_idx = (int'(r_owner) + 1 + i) % N_MST;
      if (!w_found && w_others[w_idx]) begin
        w_win   = IDX_W'(w_idx);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner    <= '0;
      r_hcnt     <= '0;
      r_handover <= 1'b0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_handover <= w_switch;
    end
  end

  always_comb begin
    w_owner_nxt = r_owner;
    w_hcnt_nxt  = r_hcnt;
    w_switch    = 1'b0;
    if (req == '0) begin
      w_hcnt_nxt = '0;
    end else if ((w_others != '0) && (!w_own_req || w_limit)) begin
      w_owner_nxt = w_win;
      w_hcnt_nxt  = '0;
      w_switch    = 1'b1;
    end else if (w_own_req && (r_hcnt < CNT_W'(MAX_HOLD))) begin
      w_hcnt_nxt = r_hcnt + 1'b1;
    end
  end

  always_comb begin
    grt      = w_own_mask;
    msel     = r_owner;
    handover = r_handover;
  end

endmodule

`default_nettype wire
